// File: rtl/num24_round_ctrl_pkg.sv
// Shared types and constants for the 24-game round controller:
// state encodings, operator codes and keypad codes.
package num24_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PICK_A  = 3'd1,
        ST_PICK_OP = 3'd2,
        ST_PICK_B  = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WIN     = 3'd5,
        ST_LOSE    = 3'd6
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] KEY_ADD    = 4'hA;
    localparam logic [3:0] KEY_SUB    = 4'hB;
    localparam logic [3:0] KEY_MUL    = 4'hC;
    localparam logic [3:0] KEY_DIV    = 4'hD;
    localparam logic [3:0] KEY_CANCEL = 4'hF;

    function automatic logic is_op_key(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    // Operator keys are contiguous, so the op code is the offset from KEY_ADD.
    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        return 2'(k - KEY_ADD);
    endfunction

endpackage

// File: rtl/num24_alu.sv
// Combinational operand ALU: computes a (op) b and flags whether the result
// is a legal unsigned W-bit value (no underflow/overflow, exact division).
module num24_alu
    import num24_round_ctrl_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] result,
    output logic         legal
);

    localparam int unsigned PW = 2 * W;

    logic [W:0]    sum;
    logic [PW-1:0] prod;
    logic [W-1:0]  divisor;
    logic [W-1:0]  quot;
    logic [W-1:0]  rmd;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        prod    = PW'(a) * PW'(b);
        // Divide-by-zero is flagged illegal; divide by one to keep the divider defined.
        divisor = (b == '0) ? W'(1) : b;
        quot    = a / divisor;
        rmd     = a % divisor;
        result  = '0;
        legal   = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[W-1:0];
                legal  = ~sum[W];
            end
            OP_SUB: begin
                result = a - b;
                legal  = (a >= b);
            end
            OP_MUL: begin
                result = prod[W-1:0];
                legal  = (prod[PW-1:W] == '0);
            end
            default: begin
                result = quot;
                legal  = (b != '0) && (rmd == '0);
            end
        endcase
    end

endmodule

// File: rtl/num24_round_ctrl.sv
// Round controller for the 24 game: loads NUM_CNT operands, walks the
// pick-operand/operator/operand key sequence and reports win or lose.
module num24_round_ctrl
    import num24_round_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CNT = 4,
    parameter int unsigned W       = 10,
    parameter int unsigned TARGET  = 24,
    parameter int unsigned SW      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 restart,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic [NUM_CNT*W-1:0] seed_vals,
    output logic [NUM_CNT*W-1:0] nums,
    output logic [NUM_CNT-1:0]   valid_mask,
    output logic [SW-1:0]        sel1,
    output logic [SW-1:0]        sel2,
    output logic [1:0]           op,
    output logic                 err,
    output logic                 win,
    output logic                 lose,
    output logic                 busy
);

    localparam int unsigned NW = NUM_CNT * W;
    localparam int unsigned CW = $clog2(NUM_CNT + 1);

    state_e             state_q, state_d;
    logic [NW-1:0]      nums_q, nums_d;
    logic [NW-1:0]      orig_q, orig_d;
    logic [NUM_CNT-1:0] mask_q, mask_d;
    logic [CW-1:0]      remain_q, remain_d;
    logic [SW-1:0]      sel1_q, sel1_d;
    logic [SW-1:0]      sel2_q, sel2_d;
    logic [1:0]         op_q, op_d;
    logic               err_q, err_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic               busy_q, busy_d;

    logic               key_slot;
    logic [SW-1:0]      key_idx;
    logic               key_live;
    logic [W-1:0]       alu_a, alu_b, alu_res;
    logic               alu_legal;

    // Key decode and operand fetch for the current selections.
    always_comb begin
        key_slot = (key_code != 4'd0) && (32'(key_code) <= NUM_CNT);
        key_idx  = SW'(key_code - 4'd1);
        key_live = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        for (int i = 0; i < int'(NUM_CNT); i++) begin
            if (SW'(i) == key_idx) key_live = mask_q[i];
            if (SW'(i) == sel1_q)  alu_a    = nums_q[i*W +: W];
            if (SW'(i) == sel2_q)  alu_b    = nums_q[i*W +: W];
        end
    end

    num24_alu #(.W(W)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (op_q),
        .result (alu_res),
        .legal  (alu_legal)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        nums_d   = nums_q;
        orig_d   = orig_q;
        mask_d   = mask_q;
        remain_d = remain_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        op_d     = op_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    nums_d   = seed_vals;
                    orig_d   = seed_vals;
                    mask_d   = '1;
                    remain_d = CW'(NUM_CNT);
                    state_d  = ST_PICK_A;
                end else if (restart && (state_q != ST_IDLE)) begin
                    nums_d   = orig_q;
                    mask_d   = '1;
                    remain_d = CW'(NUM_CNT);
                    state_d  = ST_PICK_A;
                end
            end
            default: begin
                if (restart) begin
                    nums_d   = orig_q;
                    mask_d   = '1;
                    remain_d = CW'(NUM_CNT);
                    state_d  = ST_PICK_A;
                end else if (state_q == ST_EXEC) begin
                    state_d = ST_PICK_A;
                    if (alu_legal) begin
                        for (int i = 0; i < int'(NUM_CNT); i++) begin
                            if (SW'(i) == sel2_q) nums_d[i*W +: W] = alu_res;
                            if (SW'(i) == sel1_q) mask_d[i] = 1'b0;
                        end
                        remain_d = remain_q - CW'(1);
                        if (remain_q == CW'(2)) begin
                            state_d = (alu_res == W'(TARGET)) ? ST_WIN : ST_LOSE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (key_valid) begin
                    case (state_q)
                        ST_PICK_A: begin
                            if (key_code == KEY_CANCEL) begin
                                state_d = ST_PICK_A;
                            end else if (key_slot && key_live) begin
                                sel1_d  = key_idx;
                                state_d = ST_PICK_OP;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        ST_PICK_OP: begin
                            if (is_op_key(key_code)) begin
                                op_d    = key_to_op(key_code);
                                state_d = ST_PICK_B;
                            end else if (key_code == KEY_CANCEL) begin
                                state_d = ST_PICK_A;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            if (key_code == KEY_CANCEL) begin
                                state_d = ST_PICK_A;
                            end else if (key_slot && key_live && (key_idx != sel1_q)) begin
                                sel2_d  = key_idx;
                                state_d = ST_EXEC;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase

        win_d  = (state_d == ST_WIN);
        lose_d = (state_d == ST_LOSE);
        busy_d = state_d inside {ST_PICK_A, ST_PICK_OP, ST_PICK_B, ST_EXEC};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            nums_q   <= '0;
            orig_q   <= '0;
            mask_q   <= '0;
            remain_q <= '0;
            sel1_q   <= '0;
            sel2_q   <= '0;
            op_q     <= '0;
            err_q    <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            nums_q   <= nums_d;
            orig_q   <= orig_d;
            mask_q   <= mask_d;
            remain_q <= remain_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
            op_q     <= op_d;
            err_q    <= err_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            busy_q   <= busy_d;
        end
    end

    assign nums       = nums_q;
    assign valid_mask = mask_q;
    assign sel1       = sel1_q;
    assign sel2       = sel2_q;
    assign op         = op_q;
    assign err        = err_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_num24_round_ctrl.sv
// Directed bench for num24_round_ctrl: win/lose paths, rejects, overflow,
// cancel, restart priority and asynchronous reset.
`timescale 1ns/1ps
module tb_num24_round_ctrl;

    localparam int unsigned NUM_CNT = 4;
    localparam int unsigned W       = 10;
    localparam int unsigned SW      = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 restart;
    logic                 key_valid;
    logic [3:0]           key_code;
    logic [NUM_CNT*W-1:0] seed_vals;
    logic [NUM_CNT*W-1:0] nums;
    logic [NUM_CNT-1:0]   valid_mask;
    logic [SW-1:0]        sel1, sel2;
    logic [1:0]           op;
    logic                 err, win, lose, busy;

    int total = 0;
    int bad   = 0;

    num24_round_ctrl #(.NUM_CNT(NUM_CNT), .W(W), .TARGET(24), .SW(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .restart(restart),
        .key_valid(key_valid), .key_code(key_code), .seed_vals(seed_vals),
        .nums(nums), .valid_mask(valid_mask), .sel1(sel1), .sel2(sel2), .op(op),
        .err(err), .win(win), .lose(lose), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_CNT*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [W-1:0] slot(input logic [NUM_CNT*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; restart = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [NUM_CNT*W-1:0] s);
        @(negedge clk);
        seed_vals = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    // Drives one key strobe; e is err as seen one cycle after the strobe.
    task automatic press(input logic [3:0] code, output logic e);
        @(negedge clk);
        key_valid = 1'b1; key_code = code;
        @(negedge clk);
        key_valid = 1'b0;
        e = err;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; restart = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        seed_vals = '0;
        repeat (2) @(negedge clk);
        total++; if (nums !== '0) begin bad++; $display("FAIL reset_nums: got %h want 0", nums); end
        total++; if (valid_mask !== 4'b0000) begin bad++; $display("FAIL reset_mask: got %b want 0000", valid_mask); end
        total++; if ({sel1, sel2, op} !== 6'b0) begin bad++; $display("FAIL reset_sel_op: got %b want 000000", {sel1, sel2, op}); end
        total++; if ({err, win, lose, busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {err, win, lose, busy}); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_win();
        logic e1, e2, e3;
        do_reset();
        pulse_start(pack4(4, 6, 1, 1));
        total++; if (nums !== pack4(4, 6, 1, 1)) begin bad++; $display("FAIL win_load: got %h want %h", nums, pack4(4, 6, 1, 1)); end
        total++; if ({valid_mask, busy} !== 5'b11111) begin bad++; $display("FAIL win_load_mask_busy: got %b want 11111", {valid_mask, busy}); end
        press(4'h1, e1); press(4'hC, e2); press(4'h2, e3); step();
        total++; if ({e1, e2, e3, err} !== 4'b0000) begin bad++; $display("FAIL win_op1_err: got %b want 0000", {e1, e2, e3, err}); end
        total++; if (slot(nums, 1) !== 10'd24 || valid_mask !== 4'b1110) begin bad++; $display("FAIL win_op1: got n1=%0d mask=%b want 24 1110", slot(nums, 1), valid_mask); end
        press(4'h3, e1); press(4'hC, e2); press(4'h4, e3); step();
        total++; if (slot(nums, 3) !== 10'd1 || valid_mask !== 4'b1010) begin bad++; $display("FAIL win_op2: got n3=%0d mask=%b want 1 1010", slot(nums, 3), valid_mask); end
        press(4'h2, e1); press(4'hC, e2); press(4'h4, e3); step();
        total++; if (slot(nums, 3) !== 10'd24 || valid_mask !== 4'b1000) begin bad++; $display("FAIL win_op3: got n3=%0d mask=%b want 24 1000", slot(nums, 3), valid_mask); end
        total++; if ({win, lose, busy} !== 3'b100) begin bad++; $display("FAIL win_flags: got %b want 100", {win, lose, busy}); end
        total++; if ({sel1, sel2, op} !== {2'd1, 2'd3, 2'd2}) begin bad++; $display("FAIL win_sel_op: got %b want 011110", {sel1, sel2, op}); end
        // New round straight from WIN, then a start mid-round is ignored.
        pulse_start(pack4(1, 2, 3, 4));
        total++; if (nums !== pack4(1, 2, 3, 4) || {win, busy} !== 2'b01) begin bad++; $display("FAIL win_restart_start: got %h wb=%b want %h 01", nums, {win, busy}, pack4(1, 2, 3, 4)); end
        pulse_start(pack4(9, 9, 9, 9));
        total++; if (nums !== pack4(1, 2, 3, 4)) begin bad++; $display("FAIL busy_start_ignored: got %h want %h", nums, pack4(1, 2, 3, 4)); end
    endtask

    task automatic test_rejects();
        logic e1, e2, e3;
        do_reset();
        pulse_start(pack4(3, 6, 2, 2));
        press(4'h1, e1); press(4'hB, e2); press(4'h2, e3); step();
        total++; if ({e1, e2, e3, err} !== 4'b0001) begin bad++; $display("FAIL rej_sub_err: got %b want 0001", {e1, e2, e3, err}); end
        total++; if (nums !== pack4(3, 6, 2, 2) || valid_mask !== 4'b1111) begin bad++; $display("FAIL rej_sub_nochange: got %h %b", nums, valid_mask); end
        press(4'hA, e1);
        total++; if (e1 !== 1'b1) begin bad++; $display("FAIL rej_back_pick_a: got err=%b want 1", e1); end
        do_reset();
        pulse_start(pack4(6, 4, 1, 1));
        press(4'h1, e1); press(4'hD, e2); press(4'h2, e3); step();
        total++; if ({e3, err} !== 2'b01 || nums !== pack4(6, 4, 1, 1)) begin bad++; $display("FAIL rej_div: got err=%b nums=%h", {e3, err}, nums); end
        press(4'h1, e1); press(4'hA, e2); press(4'h1, e3);
        total++; if ({e1, e2, e3} !== 3'b001) begin bad++; $display("FAIL rej_same_slot: got %b want 001", {e1, e2, e3}); end
        press(4'h2, e1); step();
        total++; if (e1 !== 1'b0 || slot(nums, 1) !== 10'd10 || valid_mask !== 4'b1110) begin bad++; $display("FAIL rej_stay_pick_b: got e=%b n1=%0d mask=%b want 0 10 1110", e1, slot(nums, 1), valid_mask); end
        press(4'h1, e1);
        total++; if (e1 !== 1'b1) begin bad++; $display("FAIL rej_dead_slot: got err=%b want 1", e1); end
        press(4'h7, e1);
        total++; if (e1 !== 1'b1) begin bad++; $display("FAIL rej_bad_key: got err=%b want 1", e1); end
    endtask

    task automatic test_overflow();
        logic e1, e2, e3;
        do_reset();
        pulse_start(pack4(1000, 2, 1, 1));
        press(4'h1, e1); press(4'hC, e2); press(4'h2, e3); step();
        total++; if (err !== 1'b1 || nums !== pack4(1000, 2, 1, 1)) begin bad++; $display("FAIL ovf_mul: got err=%b nums=%h", err, nums); end
        press(4'h1, e1); press(4'hA, e2); press(4'h3, e3); step();
        total++; if (err !== 1'b0 || slot(nums, 2) !== 10'd1001 || valid_mask !== 4'b1110) begin bad++; $display("FAIL ovf_add_legal: got err=%b n2=%0d mask=%b want 0 1001 1110", err, slot(nums, 2), valid_mask); end
    endtask

    task automatic test_lose_restart();
        logic e1, e2, e3;
        do_reset();
        pulse_start(pack4(1, 1, 1, 1));
        press(4'h1, e1); press(4'hA, e2); press(4'h2, e3); step();
        press(4'h2, e1); press(4'hA, e2); press(4'h3, e3); step();
        press(4'h3, e1); press(4'hA, e2); press(4'h4, e3); step();
        total++; if (nums !== pack4(1, 2, 3, 4) || valid_mask !== 4'b1000) begin bad++; $display("FAIL lose_nums: got %h %b want %h 1000", nums, valid_mask, pack4(1, 2, 3, 4)); end
        total++; if ({win, lose, busy} !== 3'b010) begin bad++; $display("FAIL lose_flags: got %b want 010", {win, lose, busy}); end
        pulse_restart();
        total++; if (nums !== pack4(1, 1, 1, 1) || valid_mask !== 4'b1111 || {lose, busy} !== 2'b01) begin bad++; $display("FAIL lose_restart: got %h %b lb=%b", nums, valid_mask, {lose, busy}); end
        press(4'hC, e1);
        total++; if (e1 !== 1'b1) begin bad++; $display("FAIL lose_restart_pick_a: got err=%b want 1", e1); end
    endtask

    task automatic test_cancel_priority();
        logic e1, e2, e3;
        do_reset();
        pulse_start(pack4(4, 6, 1, 1));
        press(4'h1, e1); press(4'hC, e2); press(4'hF, e3);
        total++; if ({e1, e2, e3} !== 3'b000 || sel1 !== 2'd0 || op !== 2'd2) begin bad++; $display("FAIL cancel_keys: got %b sel1=%0d op=%0d", {e1, e2, e3}, sel1, op); end
        press(4'hA, e1);
        total++; if (e1 !== 1'b1 || nums !== pack4(4, 6, 1, 1)) begin bad++; $display("FAIL cancel_to_pick_a: got err=%b nums=%h", e1, nums); end
        press(4'h1, e1); press(4'hC, e2); press(4'h2, e3); step();
        press(4'h2, e1); press(4'hA, e2);
        @(negedge clk);
        restart = 1'b1; key_valid = 1'b1; key_code = 4'h3;
        @(negedge clk);
        restart = 1'b0; key_valid = 1'b0;
        step();
        total++; if (nums !== pack4(4, 6, 1, 1) || valid_mask !== 4'b1111 || err !== 1'b0) begin bad++; $display("FAIL restart_priority: got %h %b err=%b", nums, valid_mask, err); end
        press(4'hC, e1);
        total++; if (e1 !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL restart_pick_a: got err=%b busy=%b want 1 1", e1, busy); end
    endtask

    task automatic test_reset_mid();
        logic e1, e2, e3;
        do_reset();
        pulse_start(pack4(4, 6, 1, 1));
        press(4'h1, e1); press(4'hC, e2); press(4'h2, e3); step();
        total++; if (slot(nums, 1) !== 10'd24) begin bad++; $display("FAIL mid_pre_op: got %0d want 24", slot(nums, 1)); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (nums !== '0 || valid_mask !== 4'b0000 || {sel1, sel2, op} !== 6'b0 || {err, win, lose, busy} !== 4'b0) begin bad++; $display("FAIL mid_async_reset: got %h %b %b %b", nums, valid_mask, {sel1, sel2, op}, {err, win, lose, busy}); end
        @(negedge clk);
        rst = 1'b1;
        pulse_start(pack4(2, 3, 4, 5));
        total++; if (nums !== pack4(2, 3, 4, 5) || valid_mask !== 4'b1111 || busy !== 1'b1) begin bad++; $display("FAIL mid_fresh_start: got %h %b busy=%b", nums, valid_mask, busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_win();
        test_rejects();
        test_overflow();
        test_lose_restart();
        test_cancel_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/num24_round_ctrl.md
Name: num24_round_ctrl

Overview:
- Parametrised round controller for the 24 game; successor to the fixed four-number game FSM.
- Generalised to NUM_CNT operands of width W with a configurable target value.
- Adds operand legality checking (underflow, overflow, non-exact division), cancel, restart-to-original and explicit win/lose results.
- Sits between the debounced buttons/keypad decoder and the number converter/VGA path; operands are loaded from the random valid-set lookup.

Parameters:
- NUM_CNT, 4, number of operands per round (2..8)
- W, 10, operand/result width in bits (unsigned)
- TARGET, 24, winning final value
- SW, 2, select width; must be >= clog2(NUM_CNT)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  debounced single-cycle pulse; begins a new round
- restart  in  1  debounced single-cycle pulse; reloads the current round's original operands
- key_valid  in  1  single-cycle strobe, one per keypad press
- key_code  in  4  decoded key (0x0-0xF)
- seed_vals  in  NUM_CNT*W  new-round operands; slot i at bits [i*W +: W]
- nums  out  NUM_CNT*W  current operand values
- valid_mask  out  NUM_CNT  1 = slot still live
- sel1  out  SW  first selected slot
- sel2  out  SW  second selected slot
- op  out  2  selected operator: 0 add, 1 sub, 2 mul, 3 div
- err  out  1  one-cycle pulse on a rejected key or operation
- win  out  1  level; set in WIN state
- lose  out  1  level; set in LOSE state
- busy  out  1  high while a round is in progress (PICK_A..EXEC)

Behaviour:
- Reset (rst=0, async): state IDLE; nums, valid_mask, sel1, sel2, op all 0; err, win, lose, busy 0. Original-operand copy cleared.
- Key map:
  - keys 0x1..NUM_CNT select slot key-1
  - 0xA add, 0xB sub, 0xC mul, 0xD div
  - 0xF cancel
  - all other keys: err pulse, no state change
- IDLE
  - On start: capture seed_vals into nums and the original copy, valid_mask all ones, remaining=NUM_CNT, go to PICK_A.
  - restart and keys ignored.
- PICK_A
  - Slot key on a live slot: sel1=slot, go to PICK_OP.
  - Dead slot or operator key: err.
  - 0xF: no-op.
- PICK_OP
  - Operator key: op latched, go to PICK_B.
  - 0xF: go to PICK_A.
  - Slot key: err.
- PICK_B
  - Slot key on a live slot != sel1: sel2=slot, go to EXEC next cycle.
  - Same slot as sel1 or dead slot: err, stay.
  - 0xF: go to PICK_A.
- EXEC (exactly one cycle); a=nums[sel1], b=nums[sel2]:
  - Legal when:
    - add: result < 2^W
    - sub: a >= b
    - mul: product < 2^W
    - div: b != 0 and a mod b == 0
  - Legal result: nums[sel2] <= result, valid_mask[sel1] <= 0, nums[sel1] unchanged, remaining-1.
    - If remaining becomes 1: go to WIN if result == TARGET, else LOSE.
    - Otherwise go to PICK_A.
  - Illegal: no change, err pulse, go to PICK_A.
  - Latency: 1 cycle from the PICK_B key strobe to the nums/valid_mask update.
- WIN / LOSE
  - win (or lose) held.
  - start: behaves as from IDLE with new seed_vals; win/lose clear.
  - restart: reload original copy, go to PICK_A.
- restart in PICK_A..EXEC: reload original copy into nums, valid_mask all ones, remaining=NUM_CNT, go to PICK_A. Takes priority over a same-cycle key_valid.
- start outside IDLE/WIN/LOSE: ignored.
- start and restart together in IDLE, WIN or LOSE: start wins.
- key_valid during EXEC: dropped.
- Async reset mid-round returns to IDLE immediately.
- busy = state in {PICK_A, PICK_OP, PICK_B, EXEC}.

Decomposition:
- Shared include file num24_defs.vh holds:
  - state encodings: IDLE, PICK_A, PICK_OP, PICK_B, EXEC, WIN, LOSE
  - operator codes
  - key-code constants: KEY_ADD=0xA, KEY_SUB=0xB, KEY_MUL=0xC, KEY_DIV=0xD, KEY_CANCEL=0xF
- One combinational sub-module, num24_alu (params W):
  - inputs a, b, op
  - outputs result[W-1:0] and legal
  - 2W-bit product for the overflow check; exact-division check via remainder.

Test Plan:
- Win path: seed {4,6,1,1} (slots 0..3), start; keys 1,C,2 -> nums[1]=24, mask 1110; keys 3,C,4 -> nums[3]=1, mask 1010; keys 2,C,4 -> nums[3]=24, mask 1000, win=1, busy=0.
- Rejects: seed {3,6,2,2}; keys 1,B,2 (3-6) -> err pulse, nums unchanged, PICK_A. Keys 2,D,… with 6/4 via seed {6,4,1,1}; keys 1,D,2 -> err, no change. Key 1,A,1 -> err in PICK_B, stays PICK_B.
- Overflow: W=10, seed {1000,2,1,1}; keys 1,C,2 -> err; keys 1,A,3 -> nums[2]=1001, legal.
- Lose, then restart: seed {1,1,1,1}; three adds -> final 4, lose=1; restart -> nums={1,1,1,1}, mask 1111, lose=0, PICK_A.
- Cancel and priority: keys 1,C then F -> PICK_A, sel1 retained but no change; restart in the same cycle as a key_valid in PICK_B -> reload wins, no EXEC.
- Reset mid-round: after one legal op, assert rst=0 asynchronously -> all outputs 0 before the next clk edge; deassert, start -> fresh seed loaded.
